// File: rtl/demux2_stream.sv
// demux2_stream: 1-to-2 stream demultiplexer. Each accepted word is steered
// by in_sel (or by an alternating pointer) into one of two channel FIFOs,
// and each FIFO drains through its own valid/ready port.

// Per-channel FIFO: registered outputs, no bypass in either direction.
module demux2_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     full,
  output logic                     valid,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign data    = valid ? mem[rd_ptr] : '0;
  // A full FIFO refuses the write even if it pops this cycle.
  assign do_push = push & ~full & ~rst;
  assign do_pop  = valid & pop_ready;

  // Storage is never cleared; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module demux2_stream #(
  parameter int WIDTH     = 1,
  parameter int DEPTH     = 4,
  parameter int ALTERNATE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  turn, tgt, accept;
  logic [1:0]            push, full, vld, rdy;
  logic [1:0][WIDTH-1:0] dat;
  logic [1:0][CW-1:0]    cnt;

  // In alternate mode a stalled word keeps its target, so order is kept
  // at the cost of head-of-line blocking between channels.
  assign tgt      = (ALTERNATE != 0) ? turn : in_sel;
  assign in_ready = ~full[tgt];
  assign accept   = in_valid & in_ready;
  assign push     = accept ? (tgt ? 2'b10 : 2'b01) : 2'b00;
  assign rdy      = {b_ready, a_ready};

  // Alternation pointer advances only on an accepted word.
  always_ff @(posedge clk) begin
    if (rst)                              turn <= 1'b0;
    else if ((ALTERNATE != 0) && accept)  turn <= ~turn;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[ch]),
      .push_data (in_data),
      .pop_ready (rdy[ch]),
      .full      (full[ch]),
      .valid     (vld[ch]),
      .data      (dat[ch]),
      .count     (cnt[ch])
    );
  end

  assign a_valid = vld[0];
  assign a_data  = dat[0];
  assign a_count = cnt[0];
  assign b_valid = vld[1];
  assign b_data  = dat[1];
  assign b_count = cnt[1];
endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: a select-mode and an alternate-mode instance,
// queue scoreboard per channel, monitor checks on the falling edge.
module tb_demux2_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // select-mode instance
  logic       sv, ss, s_ready, sa_rdy, sb_rdy, sav, sbv;
  logic [7:0] sd, sad, sbd;
  logic [2:0] sac, sbc;
  // alternate-mode instance
  logic       xv, x_ready, xa_rdy, xb_rdy, xav, xbv;
  logic [7:0] xd, xad, xbd;
  logic [2:0] xac, xbc;

  demux2_stream #(.WIDTH(8), .DEPTH(4), .ALTERNATE(0)) u_sel (
    .clk(clk), .rst(rst), .in_valid(sv), .in_sel(ss), .in_data(sd),
    .in_ready(s_ready), .a_valid(sav), .a_ready(sa_rdy), .a_data(sad),
    .b_valid(sbv), .b_ready(sb_rdy), .b_data(sbd), .a_count(sac), .b_count(sbc));

  demux2_stream #(.WIDTH(8), .DEPTH(4), .ALTERNATE(1)) u_alt (
    .clk(clk), .rst(rst), .in_valid(xv), .in_sel(1'b1), .in_data(xd),
    .in_ready(x_ready), .a_valid(xav), .a_ready(xa_rdy), .a_data(xad),
    .b_valid(xbv), .b_ready(xb_rdy), .b_data(xbd), .a_count(xac), .b_count(xbc));

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;
  bit tog_a  = 0;
  bit alt_turn = 0;
  logic [7:0] q0[$], q1[$], q2[$], q3[$];

  logic [3:0]      m_vld, m_rdy;
  logic [3:0][7:0] m_dat;
  logic [3:0][2:0] m_cnt;
  assign m_vld = {xbv, xav, sbv, sav};
  assign m_rdy = {xb_rdy, xa_rdy, sb_rdy, sa_rdy};
  assign m_dat = {xbd, xad, sbd, sad};
  assign m_cnt = {xbc, xac, sbc, sac};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int c);
    case (c)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [7:0] qhead(input int c);
    case (c)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpush(input int c, input logic [7:0] d);
    case (c)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic qpop(input int c);
    logic [7:0] t;
    case (c)
      0: t = q0.pop_front();
      1: t = q1.pop_front();
      2: t = q2.pop_front();
      default: t = q3.pop_front();
    endcase
  endtask

  function automatic string cname(input int c);
    case (c)
      0: return "sel_a";
      1: return "sel_b";
      2: return "alt_a";
      default: return "alt_b";
    endcase
  endfunction

  // Monitor: compare each channel against its scoreboard queue, pop on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 4; c++) begin
        int n;
        n = qsize(c);
        chk({cname(c), "_count"}, 32'(m_cnt[c]), 32'(n));
        chk({cname(c), "_valid"}, 32'(m_vld[c]), 32'(n != 0));
        if (n != 0) chk({cname(c), "_data"}, 32'(m_dat[c]), 32'(qhead(c)));
        else        chk({cname(c), "_data0"}, 32'(m_dat[c]), 32'd0);
        if (m_vld[c] && m_rdy[c] && n != 0) qpop(c);
      end
    end
  end

  // Advance one cycle; phase afterwards is just past the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tog_a) sa_rdy = ~sa_rdy;
  endtask

  // Offer one word, wait (bounded) for acceptance, record expectation.
  task automatic send(input bit alt, input logic sel, input logic [7:0] d);
    bit done = 0;
    logic rdy;
    if (alt) begin xv = 1; xd = d; end
    else     begin sv = 1; ss = sel; sd = d; end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      rdy = alt ? x_ready : s_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        if (alt) begin qpush(alt_turn ? 3 : 2, d); alt_turn = ~alt_turn; end
        else     qpush(sel ? 1 : 0, d);
      end
      #1;
      if (tog_a) sa_rdy = ~sa_rdy;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    if (alt) xv = 0; else sv = 0;
  endtask

  initial begin
    rst = 1; sv = 0; ss = 0; sd = 0; xv = 0; xd = 0;
    sa_rdy = 0; sb_rdy = 0; xa_rdy = 0; xb_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    mon_en = 1;
    @(negedge clk);
    chk("s_ready_after_reset", 32'(s_ready), 32'd1);
    chk("x_ready_after_reset", 32'(x_ready), 32'd1);
    cyc();

    // Basic steering, both consumers ready
    sa_rdy = 1; sb_rdy = 1;
    send(0, 0, 8'd5);
    send(0, 1, 8'd9);
    repeat (3) cyc();

    // Fill A while B still flows
    sa_rdy = 0;
    for (int i = 0; i < 4; i++) send(0, 0, 8'(i));
    @(negedge clk);
    chk("sel_a_full_count", 32'(sac), 32'd4);
    ss = 0; #1;
    chk("in_ready_to_full_a", 32'(s_ready), 32'd0);
    ss = 1; #1;
    chk("in_ready_to_b", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    send(0, 1, 8'h20);
    send(0, 1, 8'h21);

    // Full A: push rejected in the pop cycle, retry succeeds next cycle
    sv = 1; ss = 0; sd = 8'h44; sa_rdy = 1;
    @(negedge clk);
    chk("full_pop_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    sa_rdy = 0;
    @(negedge clk);
    chk("after_pop_count", 32'(sac), 32'd3);
    chk("after_pop_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    qpush(0, 8'h44);
    #1; sv = 0;
    @(negedge clk);
    chk("retry_count", 32'(sac), 32'd4);
    @(posedge clk); #1;
    sa_rdy = 1;
    repeat (6) cyc();

    // Pointer wrap with a toggling consumer
    tog_a = 1; sa_rdy = 0;
    for (int i = 0; i < 10; i++) send(0, 0, 8'h60 + 8'(i));
    tog_a = 0; sa_rdy = 1;
    repeat (6) cyc();

    // Alternate mode ordering
    xa_rdy = 1; xb_rdy = 1;
    for (int i = 1; i <= 4; i++) send(1, 1, 8'(i));
    repeat (3) cyc();
    xb_rdy = 0;
    for (int i = 0; i < 8; i++) send(1, 1, 8'h10 + 8'(i));
    send(1, 1, 8'h18);
    xv = 1; xd = 8'h19;
    @(negedge clk);
    chk("alt_b_full_ready", 32'(x_ready), 32'd0);
    chk("alt_b_full_count", 32'(xbc), 32'd4);
    cyc();
    @(negedge clk);
    chk("alt_turn_held", 32'(x_ready), 32'd0);
    @(posedge clk); #1;
    xb_rdy = 1;
    @(negedge clk);
    chk("alt_no_bypass", 32'(x_ready), 32'd0);
    @(posedge clk); #1;
    send(1, 1, 8'h19);
    repeat (6) cyc();

    // Mid-traffic reset
    xa_rdy = 0; xb_rdy = 0; sa_rdy = 0; sb_rdy = 0;
    for (int i = 0; i < 5; i++) send(1, 1, 8'hA0 + 8'(i));
    send(0, 0, 8'hB0); send(0, 0, 8'hB1);
    send(0, 1, 8'hC0); send(0, 1, 8'hC1);
    @(negedge clk);
    chk("pre_rst_alt_a", 32'(xac), 32'd3);
    chk("pre_rst_alt_b", 32'(xbc), 32'd2);
    @(posedge clk); #1;
    rst = 1; xv = 1; xd = 8'h77;
    @(posedge clk);
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    alt_turn = 0;
    #1; rst = 0; xv = 0;
    @(negedge clk);
    chk("rst_alt_a_count", 32'(xac), 32'd0);
    chk("rst_sel_b_data", 32'(sbd), 32'd0);
    @(posedge clk); #1;
    send(1, 1, 8'h55);
    @(negedge clk);
    chk("post_rst_to_a", 32'(xac), 32'd1);
    chk("post_rst_not_b", 32'(xbc), 32'd0);
    @(posedge clk); #1;
    xa_rdy = 1; xb_rdy = 1; sa_rdy = 1; sb_rdy = 1;
    repeat (4) cyc();

    mon_en = 0;
    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
